// File: rtl/cpx_magphase.sv
// rtl/cpx_magphase.sv - iterative vectoring-mode CORDIC: Re/Im to magnitude and phase
module cpx_magphase #(
   parameter int          ITER  = 12,
   parameter int          GUARD = 2,
   parameter logic [15:0] KCOMP = 16'd19899
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               EN,
   input  logic               in_valid,
   input  logic signed [12:0] Re,
   input  logic signed [12:0] Im,
   output logic        [13:0] mag,
   output logic signed [15:0] phase,
   output logic               out_valid,
   output logic               busy,
   output logic               overrun
);

   localparam int W = 15 + GUARD;
   localparam int P = W + 17;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_SCALE} state_t;

   state_t             state;
   logic        [3:0]  cnt;
   logic signed [12:0] re_q;
   logic signed [12:0] im_q;
   logic signed [W-1:0] x;
   logic signed [W-1:0] y;
   logic signed [15:0]  z;

   logic signed [W-1:0] re_ext, im_ext, x_sh, y_sh;
   logic signed [16:0]  kc;
   logic signed [P-1:0] prod, prod_r, mag_full;
   logic        [13:0]  mag_sat;
   logic        [15:0]  atan_i;
   logic                accept;

   function automatic logic [15:0] atan_lut(input logic [3:0] i);
      case (i)
         4'd0:    atan_lut = 16'd8192;
         4'd1:    atan_lut = 16'd4836;
         4'd2:    atan_lut = 16'd2555;
         4'd3:    atan_lut = 16'd1297;
         4'd4:    atan_lut = 16'd651;
         4'd5:    atan_lut = 16'd326;
         4'd6:    atan_lut = 16'd163;
         4'd7:    atan_lut = 16'd81;
         4'd8:    atan_lut = 16'd41;
         4'd9:    atan_lut = 16'd20;
         4'd10:   atan_lut = 16'd10;
         4'd11:   atan_lut = 16'd5;
         4'd12:   atan_lut = 16'd3;
         4'd13:   atan_lut = 16'd1;
         default: atan_lut = 16'd0;
      endcase
   endfunction

   // The SCALE cycle may take a new sample; the out_valid cycle (IDLE, busy) may not.
   assign accept = in_valid && ((state == S_IDLE && !busy) || state == S_SCALE);

   always_comb begin
      re_ext = {{2{re_q[12]}}, re_q, {GUARD{1'b0}}};
      im_ext = {{2{im_q[12]}}, im_q, {GUARD{1'b0}}};
      x_sh   = x >>> cnt;
      y_sh   = y >>> cnt;
      atan_i = atan_lut(cnt);
      kc     = $signed({1'b0, KCOMP});
      prod   = P'(x) * P'(kc);
      prod_r = prod + (P'(1) <<< (14 + GUARD));
      mag_full = prod_r >>> (15 + GUARD);
      if (mag_full[P-1])
         mag_sat = 14'd0;
      else if (|mag_full[P-2:14])
         mag_sat = 14'h3FFF;
      else
         mag_sat = mag_full[13:0];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         cnt       <= 4'd0;
         re_q      <= '0;
         im_q      <= '0;
         x         <= '0;
         y         <= '0;
         z         <= '0;
         mag       <= '0;
         phase     <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
      end else if (EN) begin
         out_valid <= 1'b0;
         if (in_valid && !accept)
            overrun <= 1'b1;
         case (state)
            S_IDLE: begin
               busy <= accept;
               if (accept) begin
                  re_q  <= Re;
                  im_q  <= Im;
                  state <= S_LOAD;
               end
            end
            S_LOAD: begin
               // Fold the left half-plane into the right so the iterations converge.
               if (!re_q[12]) begin
                  x <= re_ext;
                  y <= im_ext;
                  z <= 16'sd0;
               end else if (!im_q[12]) begin
                  x <= im_ext;
                  y <= -re_ext;
                  z <= 16'sd16384;
               end else begin
                  x <= -im_ext;
                  y <= re_ext;
                  z <= -16'sd16384;
               end
               cnt   <= 4'd0;
               state <= S_ITER;
            end
            S_ITER: begin
               if (!y[W-1]) begin
                  x <= x + y_sh;
                  y <= y - x_sh;
                  z <= z + $signed(atan_i);
               end else begin
                  x <= x - y_sh;
                  y <= y + x_sh;
                  z <= z - $signed(atan_i);
               end
               if (cnt == 4'(ITER - 1)) begin
                  cnt   <= 4'd0;
                  state <= S_SCALE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            S_SCALE: begin
               mag       <= mag_sat;
               phase     <= z;
               out_valid <= 1'b1;
               busy      <= 1'b1;
               if (in_valid) begin
                  re_q  <= Re;
                  im_q  <= Im;
                  state <= S_LOAD;
               end else begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
